// File: rtl/cfg_chain_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : cfg_chain_loader_if
// Brief    : Valid/ready word stream feeding the configuration chain loader.
// Revision : 1.0
// ============================================================================
interface cfg_chain_loader_if #(
    parameter int WORD_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_data;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready
    );
endinterface
`default_nettype wire

// File: rtl/cfg_chain_loader.sv
`default_nettype none
// ============================================================================
// Module   : cfg_chain_loader
// Brief    : Serialises bitstream words into a scan configuration chain, then
//            releases it with CFGE; returns old chain contents as readback.
// Revision : 1.0
// ============================================================================
module cfg_chain_loader #(
    parameter int CHAIN_LEN = 64,
    parameter int WORD_W    = 8
) (
    input  wire logic         CK,
    input  wire logic         RST,
    input  wire logic         start,
    cfg_chain_loader_if.slave in_if,
    output logic              chain_si,
    output logic              chain_se,
    output logic              chain_ck_en,
    input  wire logic         chain_tail,
    output logic              cfg_en,
    output logic              busy,
    output logic              done,
    output logic              rb_valid,
    output logic              rb_bit
);
    localparam int c_cnt_w  = $clog2(CHAIN_LEN + 1);
    localparam int c_bcnt_w = $clog2(WORD_W + 1);

    localparam logic [c_cnt_w-1:0]  c_chain_len = c_cnt_w'(CHAIN_LEN);
    localparam logic [c_cnt_w-1:0]  c_chain_last = c_cnt_w'(CHAIN_LEN - 1);
    localparam logic [c_cnt_w-1:0]  c_cnt_one   = c_cnt_w'(1);
    localparam logic [c_bcnt_w-1:0] c_word_bits = c_bcnt_w'(WORD_W);
    localparam logic [c_bcnt_w-1:0] c_bcnt_one  = c_bcnt_w'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t               r_state;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [c_bcnt_w-1:0]  r_bcnt;
    logic [WORD_W-1:0]    r_buf;
    logic                 r_in_ready;

    logic                 w_start;
    logic                 w_accept;
    logic                 w_shift;
    logic [c_cnt_w-1:0]   w_cnt_inc;
    logic [c_cnt_w-1:0]   w_nxt_cnt;
    logic [c_bcnt_w-1:0]  w_nxt_bcnt;
    logic                 w_nxt_in_shift;
    logic                 w_nxt_ready;

    assign in_if.in_ready = r_in_ready;

    assign w_start   = start && (r_state != SHIFT);
    assign w_accept  = in_if.in_valid && r_in_ready;
    assign w_shift   = (r_state == SHIFT) && (r_bcnt != '0);
    assign w_cnt_inc = r_cnt + c_cnt_one;
    assign w_nxt_cnt = w_start ? '0 : (w_shift ? w_cnt_inc : r_cnt);

    // Leftover bits of the word holding the final chain bit are discarded.
    always_comb begin
        w_nxt_bcnt = r_bcnt;
        if (w_start) begin
            w_nxt_bcnt = '0;
        end else if (w_accept) begin
            w_nxt_bcnt = c_word_bits;
        end else if (w_shift) begin
            w_nxt_bcnt = (w_cnt_inc == c_chain_len) ? '0 : (r_bcnt - c_bcnt_one);
        end
    end

    // in_ready is registered, so it is computed from next-cycle buffer state.
    assign w_nxt_in_shift = w_start || ((r_state == SHIFT) && (r_cnt != c_chain_len));
    assign w_nxt_ready    = w_nxt_in_shift && (w_nxt_cnt != c_chain_len) &&
                            ((w_nxt_bcnt == '0) ||
                             ((w_nxt_bcnt == c_bcnt_one) && (w_nxt_cnt < c_chain_last)));

    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_bcnt      <= '0;
            r_buf       <= '0;
            r_in_ready  <= 1'b0;
            chain_si    <= 1'b0;
            chain_se    <= 1'b0;
            chain_ck_en <= 1'b0;
            cfg_en      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            rb_valid    <= 1'b0;
            rb_bit      <= 1'b0;
        end else begin
            r_cnt      <= w_nxt_cnt;
            r_bcnt     <= w_nxt_bcnt;
            r_in_ready <= w_nxt_ready;
            done       <= 1'b0;
            rb_valid   <= chain_ck_en;
            if (chain_ck_en) begin
                rb_bit <= chain_tail;
            end
            if (w_accept) begin
                r_buf <= in_if.in_data;
            end else if (w_shift) begin
                r_buf <= r_buf >> 1;
            end

            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_state     <= SHIFT;
                        cfg_en      <= 1'b0;
                        busy        <= 1'b1;
                        chain_se    <= 1'b1;
                        chain_ck_en <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (r_cnt == c_chain_len) begin
                        r_state     <= DONE;
                        chain_se    <= 1'b0;
                        chain_ck_en <= 1'b0;
                        cfg_en      <= 1'b1;
                        done        <= 1'b1;
                        busy        <= 1'b0;
                    end else begin
                        chain_ck_en <= w_shift;
                        if (w_shift) begin
                            chain_si <= r_buf[0];
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end
endmodule
`default_nettype wire
